// File: rtl/arb_me_pkg.sv
// Shared definitions for the ICB N-to-1 arbiter: default field widths and grant mode encodings.
package arb_me_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned ICB_AW_DFLT    = 32;
  localparam int unsigned ICB_DW_DFLT    = 64;
  localparam int unsigned ICB_USR_W_DFLT = 1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_me_fifo.sv
// Simple synchronous FIFO: input ready is judged on registered occupancy only, and the head is not zeroed when empty.
module arb_me_fifo
  import arb_me_pkg::*;
#(
  parameter int unsigned DP = 4,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  localparam int unsigned PW = clog2_min1(DP);
  localparam int unsigned CW = $clog2(DP + 1);

  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  assign i_rdy = (cnt_q != CW'(DP));
  assign o_vld = (cnt_q != '0);
  assign o_dat = mem_q[rptr_q];
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PW'(DP - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PW'(DP - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= i_dat;
  end

endmodule

// File: rtl/arb_me.sv
// ICB N-to-1 arbiter: fixed-priority or round-robin command grant, held across slave stalls, with in-order response routing.
module arb_me
  import arb_me_pkg::*;
#(
  parameter int unsigned AW              = ICB_AW_DFLT,
  parameter int unsigned DW              = ICB_DW_DFLT,
  parameter int unsigned USR_W           = ICB_USR_W_DFLT,
  parameter int unsigned ARB_NUM         = 4,
  parameter int unsigned ARB_MODE        = 1,
  parameter int unsigned FIFO_DP         = 4,
  parameter int unsigned ALLOW_0CYCL_RSP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ARB_NUM-1:0]         i_bus_icb_cmd_vld,
  output logic [ARB_NUM-1:0]         i_bus_icb_cmd_rdy,
  input  logic [ARB_NUM-1:0]         i_bus_icb_cmd_read,
  input  logic [ARB_NUM*AW-1:0]      i_bus_icb_cmd_addr,
  input  logic [ARB_NUM*DW-1:0]      i_bus_icb_cmd_wdata,
  input  logic [ARB_NUM*(DW/8)-1:0]  i_bus_icb_cmd_wmask,
  input  logic [ARB_NUM*USR_W-1:0]   i_bus_icb_cmd_usr,
  output logic [ARB_NUM-1:0]         i_bus_icb_rsp_vld,
  input  logic [ARB_NUM-1:0]         i_bus_icb_rsp_rdy,
  output logic [ARB_NUM-1:0]         i_bus_icb_rsp_err,
  output logic [ARB_NUM*DW-1:0]      i_bus_icb_rsp_rdata,
  output logic [ARB_NUM*USR_W-1:0]   i_bus_icb_rsp_usr,
  output logic                       o_icb_cmd_vld,
  input  logic                       o_icb_cmd_rdy,
  output logic                       o_icb_cmd_read,
  output logic [AW-1:0]              o_icb_cmd_addr,
  output logic [DW-1:0]              o_icb_cmd_wdata,
  output logic [DW/8-1:0]            o_icb_cmd_wmask,
  output logic [USR_W-1:0]           o_icb_cmd_usr,
  input  logic                       o_icb_rsp_vld,
  output logic                       o_icb_rsp_rdy,
  input  logic                       o_icb_rsp_err,
  input  logic [DW-1:0]              o_icb_rsp_rdata,
  input  logic [USR_W-1:0]           o_icb_rsp_usr
);

  if (ARB_NUM == 1) begin : g_wire
    assign o_icb_cmd_vld       = i_bus_icb_cmd_vld;
    assign i_bus_icb_cmd_rdy   = o_icb_cmd_rdy;
    assign o_icb_cmd_read      = i_bus_icb_cmd_read;
    assign o_icb_cmd_addr      = i_bus_icb_cmd_addr;
    assign o_icb_cmd_wdata     = i_bus_icb_cmd_wdata;
    assign o_icb_cmd_wmask     = i_bus_icb_cmd_wmask;
    assign o_icb_cmd_usr       = i_bus_icb_cmd_usr;
    assign i_bus_icb_rsp_vld   = o_icb_rsp_vld;
    assign o_icb_rsp_rdy       = i_bus_icb_rsp_rdy;
    assign i_bus_icb_rsp_err   = o_icb_rsp_err;
    assign i_bus_icb_rsp_rdata = o_icb_rsp_rdata;
    assign i_bus_icb_rsp_usr   = o_icb_rsp_usr;
  end else begin : g_arb
    localparam int unsigned IW       = clog2_min1(ARB_NUM);
    localparam int unsigned MW       = DW / 8;
    localparam arb_mode_e   MODE     = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;
    localparam bit          ZERO_CYC = (ALLOW_0CYCL_RSP != 0);

    logic               lock_vld_q, lock_vld_d;
    logic [ARB_NUM-1:0] lock_sel_q, lock_sel_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ARB_NUM-1:0] gnt, rsp_sel, fifo_o_dat;
    logic [IW-1:0]      gnt_idx;
    logic               cmd_en, cmd_hsk, rsp_hsk, bypass;
    logic               fifo_o_vld, fifo_i_vld;

    always_comb begin : p_grant
      logic        found;
      int unsigned idx;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      if (lock_vld_q) begin
        gnt = lock_sel_q;
      end else if (MODE == ARB_FIXED) begin
        for (int unsigned k = 0; k < ARB_NUM; k++) begin
          if (i_bus_icb_cmd_vld[k] && !found) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
          end
        end
      end else begin
        // Search starts at rr_ptr and wraps, so the last-served master has lowest priority.
        for (int unsigned k = 0; k < ARB_NUM; k++) begin
          idx = (32'(rr_ptr_q) + k) % ARB_NUM;
          if (i_bus_icb_cmd_vld[idx] && !found) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end

    always_comb begin
      gnt_idx = '0;
      for (int unsigned k = 0; k < ARB_NUM; k++) begin
        if (gnt[k]) gnt_idx = IW'(k);
      end
    end

    always_comb begin
      o_icb_cmd_read  = 1'b0;
      o_icb_cmd_addr  = '0;
      o_icb_cmd_wdata = '0;
      o_icb_cmd_wmask = '0;
      o_icb_cmd_usr   = '0;
      for (int unsigned k = 0; k < ARB_NUM; k++) begin
        o_icb_cmd_read  = o_icb_cmd_read  | (i_bus_icb_cmd_read[k] & gnt[k]);
        o_icb_cmd_addr  = o_icb_cmd_addr  | (i_bus_icb_cmd_addr[k*AW +: AW] & {AW{gnt[k]}});
        o_icb_cmd_wdata = o_icb_cmd_wdata | (i_bus_icb_cmd_wdata[k*DW +: DW] & {DW{gnt[k]}});
        o_icb_cmd_wmask = o_icb_cmd_wmask | (i_bus_icb_cmd_wmask[k*MW +: MW] & {MW{gnt[k]}});
        o_icb_cmd_usr   = o_icb_cmd_usr   | (i_bus_icb_cmd_usr[k*USR_W +: USR_W] & {USR_W{gnt[k]}});
      end
    end

    assign o_icb_cmd_vld     = (|gnt) & cmd_en;
    assign i_bus_icb_cmd_rdy = gnt & {ARB_NUM{o_icb_cmd_rdy & cmd_en}};
    assign cmd_hsk           = o_icb_cmd_vld & o_icb_cmd_rdy;

    always_comb begin
      if (fifo_o_vld)    rsp_sel = fifo_o_dat;
      else if (ZERO_CYC) rsp_sel = gnt;
      else               rsp_sel = '0;
    end

    assign o_icb_rsp_rdy       = |(rsp_sel & i_bus_icb_rsp_rdy);
    assign rsp_hsk             = o_icb_rsp_vld & o_icb_rsp_rdy;
    assign i_bus_icb_rsp_vld   = rsp_sel & {ARB_NUM{o_icb_rsp_vld}};
    assign i_bus_icb_rsp_err   = rsp_sel & {ARB_NUM{o_icb_rsp_err}};
    assign i_bus_icb_rsp_rdata = {ARB_NUM{o_icb_rsp_rdata}};
    assign i_bus_icb_rsp_usr   = {ARB_NUM{o_icb_rsp_usr}};

    // A same-cycle response to a command issued with nothing outstanding never enters the FIFO.
    assign bypass     = ZERO_CYC & ~fifo_o_vld & cmd_hsk & rsp_hsk;
    assign fifo_i_vld = cmd_hsk & ~bypass;

    arb_me_fifo #(
      .DP (FIFO_DP),
      .DW (ARB_NUM)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .i_vld (fifo_i_vld),
      .i_rdy (cmd_en),
      .i_dat (gnt),
      .o_vld (fifo_o_vld),
      .o_rdy (rsp_hsk),
      .o_dat (fifo_o_dat)
    );

    always_comb begin
      lock_vld_d = lock_vld_q;
      lock_sel_d = lock_sel_q;
      rr_ptr_d   = rr_ptr_q;
      if (o_icb_cmd_vld && !o_icb_cmd_rdy) begin
        lock_vld_d = 1'b1;
        lock_sel_d = gnt;
      end else if (cmd_hsk) begin
        lock_vld_d = 1'b0;
      end
      if (cmd_hsk) rr_ptr_d = (gnt_idx == IW'(ARB_NUM - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lock_vld_q <= 1'b0;
        lock_sel_q <= '0;
        rr_ptr_q   <= '0;
      end else begin
        lock_vld_q <= lock_vld_d;
        lock_sel_q <= lock_sel_d;
        rr_ptr_q   <= rr_ptr_d;
      end
    end
  end

endmodule

// File: tb/tb_arb_me.sv
// Bench for arb_me: three instances (RR+bypass, fixed+bypass, RR without bypass), ARB_NUM=3, FIFO_DP=2.
module tb_arb_me;

  logic         clk;
  logic         rst;
  logic [2:0]   cmd_vld, cmd_read, usr_in, rsp_rdy;
  logic [95:0]  addr_in;
  logic [191:0] wdata_in;
  logic [23:0]  wmask_in;
  logic         s_cmd_rdy, s_rsp_vld, s_rsp_err, s_rsp_usr;
  logic [63:0]  s_rsp_rdata;

  logic [2:0]   m_cmd_rdy [3];
  logic [2:0]   m_rsp_vld [3];
  logic [2:0]   m_rsp_err [3];
  logic [191:0] m_rsp_rdata [3];
  logic [2:0]   m_rsp_usr [3];
  logic         o_vld [3];
  logic         o_read [3];
  logic [31:0]  o_addr [3];
  logic [63:0]  o_wdata [3];
  logic [7:0]   o_wmask [3];
  logic         o_usr [3];
  logic         o_rsp_rdy [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    arb_me #(
      .AW              (32),
      .DW              (64),
      .USR_W           (1),
      .ARB_NUM         (3),
      .ARB_MODE        ((g == 1) ? 0 : 1),
      .FIFO_DP         (2),
      .ALLOW_0CYCL_RSP ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_bus_icb_cmd_vld   (cmd_vld),
      .i_bus_icb_cmd_rdy   (m_cmd_rdy[g]),
      .i_bus_icb_cmd_read  (cmd_read),
      .i_bus_icb_cmd_addr  (addr_in),
      .i_bus_icb_cmd_wdata (wdata_in),
      .i_bus_icb_cmd_wmask (wmask_in),
      .i_bus_icb_cmd_usr   (usr_in),
      .i_bus_icb_rsp_vld   (m_rsp_vld[g]),
      .i_bus_icb_rsp_rdy   (rsp_rdy),
      .i_bus_icb_rsp_err   (m_rsp_err[g]),
      .i_bus_icb_rsp_rdata (m_rsp_rdata[g]),
      .i_bus_icb_rsp_usr   (m_rsp_usr[g]),
      .o_icb_cmd_vld       (o_vld[g]),
      .o_icb_cmd_rdy       (s_cmd_rdy),
      .o_icb_cmd_read      (o_read[g]),
      .o_icb_cmd_addr      (o_addr[g]),
      .o_icb_cmd_wdata     (o_wdata[g]),
      .o_icb_cmd_wmask     (o_wmask[g]),
      .o_icb_cmd_usr       (o_usr[g]),
      .o_icb_rsp_vld       (s_rsp_vld),
      .o_icb_rsp_rdy       (o_rsp_rdy[g]),
      .o_icb_rsp_err       (s_rsp_err),
      .o_icb_rsp_rdata     (s_rsp_rdata),
      .o_icb_rsp_usr       (s_rsp_usr)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input int unsigned m);
    return 32'h1000 * (m + 1);
  endfunction

  function automatic logic [63:0] wtag(input int unsigned m);
    return 64'hDA7A_0000_0000_0000 | 64'(m + 1);
  endfunction

  task automatic set_defaults();
    cmd_vld     = '0;
    cmd_read    = 3'b101;
    usr_in      = 3'b010;
    rsp_rdy     = 3'b111;
    addr_in     = {tag(2), tag(1), tag(0)};
    wdata_in    = {wtag(2), wtag(1), wtag(0)};
    wmask_in    = 24'hFF0F_F0;
    s_cmd_rdy   = 1'b1;
    s_rsp_vld   = 1'b0;
    s_rsp_err   = 1'b0;
    s_rsp_usr   = 1'b0;
    s_rsp_rdata = '0;
  endtask

  // Leaves the bench at a negedge with reset released.
  task automatic test_reset();
    set_defaults();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({m_cmd_rdy[g], m_rsp_vld[g], o_vld[g], o_rsp_rdy[g]} !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle dut%0d: got cmd_rdy=%b rsp_vld=%b cmd_vld=%b rsp_rdy=%b expected all 0",
                 g, m_cmd_rdy[g], m_rsp_vld[g], o_vld[g], o_rsp_rdy[g]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [31:0] slq[$];
    int unsigned exp_cmd[$];
    int unsigned exp_rsp[$];
    int unsigned m;
    int ncmd = 0;
    int nrsp = 0;
    for (int i = 0; i < 6; i++) exp_cmd.push_back(i % 3);
    cmd_vld = 3'b111;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) cmd_vld = '0;
      s_rsp_vld   = (slq.size() > 0);
      s_rsp_rdata = (slq.size() > 0) ? {32'h0, slq[0]} : '0;
      #1;
      if (s_rsp_vld) begin
        checks++;
        if (!o_rsp_rdy[0] || exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rr_rsp_accept c%0d: got rdy=%b pending=%0d expected rdy=1 with pending rsp", c, o_rsp_rdy[0], exp_rsp.size());
        end else begin
          m = exp_rsp.pop_front();
          if (m_rsp_vld[0] !== 3'(1 << m) || m_rsp_rdata[0][m*64 +: 64] !== {32'h0, tag(m)}) begin
            errors++;
            $display("FAIL rr_rsp_route c%0d: got vld=%b data=%h expected vld=%b data=%h",
                     c, m_rsp_vld[0], m_rsp_rdata[0][m*64 +: 64], 3'(1 << m), {32'h0, tag(m)});
          end
          void'(slq.pop_front());
          nrsp++;
        end
      end
      if (o_vld[0] && s_cmd_rdy) begin
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL rr_extra_cmd c%0d: got addr=%h expected no handshake", c, o_addr[0]);
        end else begin
          m = exp_cmd.pop_front();
          if (m_cmd_rdy[0] !== 3'(1 << m) || o_addr[0] !== tag(m) || o_wdata[0] !== wtag(m) ||
              o_read[0] !== cmd_read[m] || o_usr[0] !== usr_in[m]) begin
            errors++;
            $display("FAIL rr_cmd_order c%0d: got rdy=%b addr=%h wdata=%h expected rdy=%b addr=%h wdata=%h",
                     c, m_cmd_rdy[0], o_addr[0], o_wdata[0], 3'(1 << m), tag(m), wtag(m));
          end
          slq.push_back(o_addr[0]);
          exp_rsp.push_back(m);
          ncmd++;
        end
      end
      @(negedge clk);
    end
    s_rsp_vld = 1'b0;
    checks++;
    if (ncmd != 6 || nrsp != 6) begin
      errors++;
      $display("FAIL rr_counts: got cmds=%0d rsps=%0d expected 6 and 6", ncmd, nrsp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  rdy;
  } cmd_exp_t;

  task automatic test_lock_stall();
    logic [2:0] vt [5] = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b011};
    logic       rt [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    cmd_exp_t   sb[$];
    cmd_exp_t   e;
    addr_in[63:32] = 32'h100;
    for (int c = 0; c < 5; c++) begin
      cmd_vld   = vt[c];
      s_cmd_rdy = rt[c];
      if (c < 4) sb.push_back('{32'h100, rt[c] ? 3'b010 : 3'b000});
      else       sb.push_back('{tag(0), 3'b001});
      #1;
      e = sb.pop_front();
      checks++;
      if (o_vld[0] !== 1'b1 || o_addr[0] !== e.addr || m_cmd_rdy[0] !== e.rdy) begin
        errors++;
        $display("FAIL lock_payload c%0d: got vld=%b addr=%h rdy=%b expected vld=1 addr=%h rdy=%b",
                 c, o_vld[0], o_addr[0], m_cmd_rdy[0], e.addr, e.rdy);
      end
      @(negedge clk);
    end
    addr_in[63:32] = tag(1);
    cmd_vld = '0;
    s_cmd_rdy = 1'b1;
  endtask

  typedef struct {
    logic [2:0] cmd_rdy;
    logic       cmd_vld;
    logic [2:0] rsp_vld;
    logic       rsp_rdy;
  } ctl_exp_t;

  task automatic test_fifo_full();
    logic     st [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ctl_exp_t ex [6] = '{'{3'b001, 1'b1, 3'b000, 1'b1}, '{3'b001, 1'b1, 3'b000, 1'b1},
                         '{3'b000, 1'b0, 3'b000, 1'b1}, '{3'b000, 1'b0, 3'b000, 1'b1},
                         '{3'b000, 1'b0, 3'b001, 1'b1}, '{3'b001, 1'b1, 3'b000, 1'b1}};
    ctl_exp_t sb[$];
    ctl_exp_t e;
    int       nacc = 0;
    cmd_vld = 3'b001;
    for (int c = 0; c < 6; c++) begin
      s_rsp_vld = st[c];
      sb.push_back(ex[c]);
      #1;
      e = sb.pop_front();
      if (o_vld[0] && s_cmd_rdy) nacc++;
      checks++;
      if (m_cmd_rdy[0] !== e.cmd_rdy || o_vld[0] !== e.cmd_vld || m_rsp_vld[0] !== e.rsp_vld || o_rsp_rdy[0] !== e.rsp_rdy) begin
        errors++;
        $display("FAIL full_ctl c%0d: got cmd_rdy=%b cmd_vld=%b rsp_vld=%b rsp_rdy=%b expected %b %b %b %b",
                 c, m_cmd_rdy[0], o_vld[0], m_rsp_vld[0], o_rsp_rdy[0], e.cmd_rdy, e.cmd_vld, e.rsp_vld, e.rsp_rdy);
      end
      @(negedge clk);
    end
    checks++;
    if (nacc != 3) begin
      errors++;
      $display("FAIL full_accept_count: got %0d expected 3", nacc);
    end
    cmd_vld = '0;
    s_rsp_vld = 1'b0;
  endtask

  task automatic test_zero_cycle_rsp();
    logic [2:0] vt [3] = '{3'b100, 3'b000, 3'b000};
    logic [3:0] ea [3] = '{{3'b100, 1'b1}, {3'b000, 1'b0}, {3'b000, 1'b0}};
    logic [3:0] eb [3] = '{{3'b000, 1'b0}, {3'b100, 1'b1}, {3'b000, 1'b0}};
    logic [3:0] sa[$];
    logic [3:0] sbq[$];
    logic [3:0] a, b;
    s_rsp_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cmd_vld = vt[c];
      sa.push_back(ea[c]);
      sbq.push_back(eb[c]);
      #1;
      a = sa.pop_front();
      b = sbq.pop_front();
      checks++;
      if ({m_rsp_vld[0], o_rsp_rdy[0]} !== a) begin
        errors++;
        $display("FAIL bypass_on c%0d: got rsp_vld=%b rsp_rdy=%b expected %b %b", c, m_rsp_vld[0], o_rsp_rdy[0], a[3:1], a[0]);
      end
      checks++;
      if ({m_rsp_vld[2], o_rsp_rdy[2]} !== b) begin
        errors++;
        $display("FAIL bypass_off c%0d: got rsp_vld=%b rsp_rdy=%b expected %b %b", c, m_rsp_vld[2], o_rsp_rdy[2], b[3:1], b[0]);
      end
      if (c == 0) begin
        checks++;
        if (m_cmd_rdy[0] !== 3'b100 || m_cmd_rdy[2] !== 3'b100) begin
          errors++;
          $display("FAIL bypass_cmd: got rdy0=%b rdy2=%b expected 100 100", m_cmd_rdy[0], m_cmd_rdy[2]);
        end
      end
      @(negedge clk);
    end
    s_rsp_vld = 1'b0;
  endtask

  task automatic test_fixed_priority();
    logic [2:0] vt [8] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b100, 3'b100};
    logic [2:0] gt [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    logic [2:0] sb[$];
    logic [2:0] e;
    s_rsp_vld = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cmd_vld = vt[c];
      sb.push_back(gt[c]);
      #1;
      e = sb.pop_front();
      checks++;
      if (m_cmd_rdy[1] !== e || m_rsp_vld[1] !== e) begin
        errors++;
        $display("FAIL fixed_grant c%0d: got cmd_rdy=%b rsp_vld=%b expected %b", c, m_cmd_rdy[1], m_rsp_vld[1], e);
      end
      @(negedge clk);
    end
    s_rsp_vld = 1'b0;
    cmd_vld = '0;
  endtask

  task automatic test_reset_mid_op();
    logic [2:0]  vt [4] = '{3'b010, 3'b111, 3'b111, 3'b111};
    logic        rt [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    cmd_exp_t    ex [4] = '{'{tag(1), 3'b000}, '{tag(1), 3'b000}, '{tag(1), 3'b010}, '{tag(2), 3'b000}};
    cmd_exp_t    sb[$];
    cmd_exp_t    e;
    for (int c = 0; c < 4; c++) begin
      cmd_vld   = vt[c];
      s_cmd_rdy = rt[c];
      sb.push_back(ex[c]);
      #1;
      e = sb.pop_front();
      checks++;
      if (o_addr[0] !== e.addr || m_cmd_rdy[0] !== e.rdy) begin
        errors++;
        $display("FAIL pre_rst c%0d: got addr=%h rdy=%b expected addr=%h rdy=%b", c, o_addr[0], m_cmd_rdy[0], e.addr, e.rdy);
      end
      @(negedge clk);
    end
    cmd_vld   = '0;
    s_cmd_rdy = 1'b0;
    s_rsp_vld = 1'b1;
    #1;
    checks++;
    if (o_rsp_rdy[0] !== 1'b1 || m_rsp_vld[0] !== 3'b010) begin
      errors++;
      $display("FAIL pre_rst_outstanding: got rsp_rdy=%b rsp_vld=%b expected 1 010", o_rsp_rdy[0], m_rsp_vld[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_rsp_rdy[0] !== 1'b0 || m_rsp_vld[0] !== 3'b000 || m_cmd_rdy[0] !== 3'b000) begin
      errors++;
      $display("FAIL rst_flush: got rsp_rdy=%b rsp_vld=%b cmd_rdy=%b expected 0 000 000", o_rsp_rdy[0], m_rsp_vld[0], m_cmd_rdy[0]);
    end
    @(negedge clk);
    rst       = 1'b1;
    s_rsp_vld = 1'b0;
    cmd_vld   = 3'b111;
    #1;
    checks++;
    if (o_addr[0] !== tag(0) || o_vld[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_grant: got vld=%b addr=%h expected 1 %h", o_vld[0], o_addr[0], tag(0));
    end
    @(negedge clk);
    s_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (m_cmd_rdy[0] !== 3'b001) begin
      errors++;
      $display("FAIL post_rst_hsk: got rdy=%b expected 001", m_cmd_rdy[0]);
    end
    @(negedge clk);
    cmd_vld = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    set_defaults();
    test_reset();
    test_round_robin();
    test_reset();
    test_lock_stall();
    test_reset();
    test_fifo_full();
    test_reset();
    test_zero_cycle_rsp();
    test_reset();
    test_fixed_priority();
    test_reset();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
